pwm_audio_nch: RTL and testbench

PWM_AUDIO_NCH -- requirements
Module: pwm_audio_nch

---
 rtl/pwm_audio_nch.sv | 101 ++++++++++
 tb/tb_pwm_audio_nch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_audio_nch.sv
// Multi-channel PWM audio output. Each channel has a one-deep shadow buffer
// that feeds its duty register once per frame, with sticky underrun flagging.
module pwm_audio_nch #(
  parameter int NCH   = 5,
  parameter int WIDTH = 8
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       s_valid,
  input  logic [NCH*WIDTH-1:0] s_data,
  output logic [NCH-1:0]       s_ready,
  input  logic [NCH*3-1:0]     atten,
  input  logic [NCH-1:0]       enable,
  input  logic                 clr_underrun,
  output logic [NCH-1:0]       pwm_out,
  output logic                 frame_tick,
  output logic [NCH-1:0]       underrun
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [WIDTH-1:0] attenuate(input logic [WIDTH-1:0] smp,
                                                 input logic [2:0]       sh);
    return smp >> sh;
  endfunction

  logic [WIDTH-1:0] r_cnt;
  logic             r_frame_tick;
  logic [NCH-1:0]   r_full;
  logic [NCH-1:0]   r_pwm;
  logic [NCH-1:0]   r_underrun;
  logic [WIDTH-1:0] r_shadow [NCH];
  logic [WIDTH-1:0] r_duty   [NCH];

  logic             w_boundary;
  logic [NCH-1:0]   w_accept;
  logic [NCH-1:0]   w_transfer;
  logic [NCH-1:0]   w_starve;

  assign w_boundary = (r_cnt == CNT_MAX);

  always_comb begin
    w_accept   = s_valid & ~r_full;
    w_transfer = '0;
    w_starve   = '0;
    if (w_boundary) begin
      w_transfer = r_full;
      w_starve   = ~r_full & enable;
    end
  end

  // Frame counter; the tick lines up with the cycle where cnt reads zero
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
      r_frame_tick <= w_boundary;
    end
  end

  // A new starvation event wins over a coincident clear
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= '0;
    end else begin
      r_underrun <= (clr_underrun ? '0 : r_underrun) | w_starve;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
      r_pwm  <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_shadow[c] <= '0;
        r_duty[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_accept[c]) begin
          r_shadow[c] <= s_data[c*WIDTH +: WIDTH];
        end
        if (w_transfer[c]) begin
          r_duty[c] <= attenuate(r_shadow[c], atten[c*3 +: 3]);
          r_full[c] <= 1'b0;
        end else if (w_accept[c]) begin
          r_full[c] <= 1'b1;
        end
        r_pwm[c] <= enable[c] && (r_cnt < r_duty[c]);
      end
    end
  end

  assign s_ready    = ~r_full;
  assign pwm_out    = r_pwm;
  assign frame_tick = r_frame_tick;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_pwm_audio_nch.sv
// Bench for pwm_audio_nch (NCH=5, WIDTH=8): table of per-channel loads with a
// scoreboard of expected high-cycle counts, plus underrun/backpressure/reset sequences.
module tb_pwm_audio_nch;
  localparam int NCH   = 5;
  localparam int WIDTH = 8;
  localparam int FRAME = 256;

  logic                 sysclk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       s_valid;
  logic [NCH*WIDTH-1:0] s_data;
  logic [NCH-1:0]       s_ready;
  logic [NCH*3-1:0]     atten;
  logic [NCH-1:0]       enable;
  logic                 clr_underrun;
  logic [NCH-1:0]       pwm_out;
  logic                 frame_tick;
  logic [NCH-1:0]       underrun;

  pwm_audio_nch #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .atten        (atten),
    .enable       (enable),
    .clr_underrun (clr_underrun),
    .pwm_out      (pwm_out),
    .frame_tick   (frame_tick),
    .underrun     (underrun)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [4:0]      en;
    logic [4:0][7:0] smp;
    logic [4:0][2:0] att;
    logic [4:0][8:0] exp;
  } vec_t;

  typedef struct {
    int ch;
    int exp;
  } sb_t;

  vec_t vecs [4];
  sb_t  sbq [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input int ch, input int exp);
    sb_t e;
    e.ch  = ch;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic wait_tick(input string name);
    int k;
    k = 0;
    do begin
      @(negedge sysclk);
      k++;
    end while (frame_tick !== 1'b1 && k < 600);
    check({name, " frame_tick reached"}, int'(frame_tick === 1'b1), 1);
  endtask

  task automatic wait_first_tick(input string name);
    int k;
    k = 0;
    do begin
      @(negedge sysclk);
      k++;
    end while (frame_tick !== 1'b1 && k < 600);
    check({name, " cycles to first frame_tick"}, k, FRAME);
  endtask

  // Entered at the negedge of a cnt==0 cycle; counts one whole frame.
  task automatic measure();
    int hi    [NCH];
    int first [NCH];
    int last  [NCH];
    sb_t e;
    for (int c = 0; c < NCH; c++) begin
      hi[c] = 0; first[c] = -1; last[c] = -1;
    end
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge sysclk);
      for (int c = 0; c < NCH; c++) begin
        if (pwm_out[c] === 1'b1) begin
          hi[c]++;
          if (first[c] < 0) first[c] = i;
          last[c] = i;
        end
      end
    end
    check("frame_tick at frame end", int'(frame_tick === 1'b1), 1);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check($sformatf("ch%0d high count", e.ch), hi[e.ch], e.exp);
      if (e.exp > 0) begin
        check($sformatf("ch%0d first high index", e.ch), first[e.ch], 1);
        check($sformatf("ch%0d contiguous run", e.ch), last[e.ch] - first[e.ch] + 1, e.exp);
      end
    end
  endtask

  initial begin
    // channel order inside each concatenation: ch4, ch3, ch2, ch1, ch0
    vecs[0].en  = 5'b11111;
    vecs[0].smp = {8'h10, 8'h00, 8'hFF, 8'h80, 8'h40};
    vecs[0].att = {3'd1, 3'd0, 3'd0, 3'd2, 3'd0};
    vecs[0].exp = {9'd8, 9'd0, 9'd255, 9'd32, 9'd64};
    vecs[1].en  = 5'b01111;
    vecs[1].smp = {8'h80, 8'hC8, 8'h7F, 8'h01, 8'hFF};
    vecs[1].att = {3'd0, 3'd0, 3'd3, 3'd0, 3'd7};
    vecs[1].exp = {9'd0, 9'd200, 9'd15, 9'd1, 9'd1};
    vecs[2].en  = 5'b11111;
    vecs[2].smp = {8'h80, 8'hAA, 8'h33, 8'hFF, 8'h00};
    vecs[2].att = {3'd0, 3'd4, 3'd0, 3'd1, 3'd0};
    vecs[2].exp = {9'd128, 9'd10, 9'd51, 9'd127, 9'd0};
    vecs[3].en  = 5'b11111;
    vecs[3].smp = {8'h01, 8'h02, 8'hFE, 8'h40, 8'hFF};
    vecs[3].att = {3'd1, 3'd0, 3'd0, 3'd6, 3'd0};
    vecs[3].exp = {9'd0, 9'd2, 9'd254, 9'd1, 9'd255};

    rst_n        = 1'b0;
    s_valid      = '0;
    s_data       = '0;
    atten        = '0;
    enable       = '0;
    clr_underrun = 1'b0;

    repeat (10) @(negedge sysclk);
    check("reset pwm_out",    int'(pwm_out),    0);
    check("reset underrun",   int'(underrun),   0);
    check("reset s_ready",    int'(s_ready),    31);
    check("reset frame_tick", int'(frame_tick), 0);
    rst_n = 1'b1;
    wait_first_tick("release");

    for (int v = 0; v < 4; v++) begin
      enable  = vecs[v].en;
      s_data  = vecs[v].smp;
      atten   = vecs[v].att;
      s_valid = '1;
      for (int c = 0; c < NCH; c++) push(c, int'(vecs[v].exp[c]));
      @(negedge sysclk);
      s_valid = '0;
      check($sformatf("vec%0d s_ready while buffered", v), int'(s_ready), 0);
      wait_tick($sformatf("vec%0d", v));
      check($sformatf("vec%0d s_ready after boundary", v), int'(s_ready), 31);
      atten = '1;
      measure();
    end

    // underrun: set, retain duty, clear, and clear coincident with a new set
    enable       = 5'b01111;
    clr_underrun = 1'b1;
    @(negedge sysclk);
    clr_underrun = 1'b0;
    check("underrun after clear", int'(underrun), 0);
    s_valid = 5'b00001;
    s_data  = 40'h40;
    atten   = '0;
    @(negedge sysclk);
    s_valid = '0;
    wait_tick("ur load");
    check("underrun unfed ch1-3 only", int'(underrun), 5'b01110);
    wait_tick("ur starve");
    check("underrun ch0 starved", int'(underrun), 5'b01111);
    push(0, 64);
    measure();
    clr_underrun = 1'b1;
    @(negedge sysclk);
    clr_underrun = 1'b0;
    check("underrun clr pulse", int'(underrun), 0);
    wait_tick("ur coincide");
    repeat (255) @(negedge sysclk);
    clr_underrun = 1'b1;
    @(negedge sysclk);
    clr_underrun = 1'b0;
    check("coincide frame_tick", int'(frame_tick), 1);
    check("underrun set wins over clear", int'(underrun), 5'b01111);

    // backpressure: second sample in a frame is dropped
    s_valid      = 5'b00001;
    s_data       = 40'h40;
    clr_underrun = 1'b1;
    @(negedge sysclk);
    clr_underrun = 1'b0;
    check("bp s_ready[0] after first", int'(s_ready[0]), 0);
    check("bp underrun cleared", int'(underrun), 0);
    s_data = 40'hC0;
    @(negedge sysclk);
    s_valid = '0;
    check("bp s_ready[0] after second", int'(s_ready[0]), 0);
    wait_tick("bp");
    push(0, 64);
    measure();

    // sample landing exactly on the boundary edge
    clr_underrun = 1'b1;
    @(negedge sysclk);
    clr_underrun = 1'b0;
    check("bp underrun[0] cleared", int'(underrun[0]), 0);
    repeat (254) @(negedge sysclk);
    s_valid = 5'b00001;
    s_data  = 40'h20;
    @(negedge sysclk);
    s_valid = '0;
    check("edge sample frame_tick", int'(frame_tick), 1);
    check("edge sample underrun[0]", int'(underrun[0]), 1);
    check("edge sample buffered", int'(s_ready[0]), 0);
    push(0, 64);
    measure();
    push(0, 32);
    measure();

    // asynchronous reset in the middle of a high pulse
    for (int i = 1; i <= 30; i++) begin
      @(negedge sysclk);
      if (i == 10) begin
        s_valid = 5'b00010;
        s_data  = 40'h5500;
      end
      if (i == 11) s_valid = '0;
    end
    check("mid-frame pwm_out[0] high", int'(pwm_out[0]), 1);
    check("mid-frame ch1 buffered", int'(s_ready[1]), 0);
    #1 rst_n = 1'b0;
    #1;
    check("async reset pwm_out",    int'(pwm_out),    0);
    check("async reset underrun",   int'(underrun),   0);
    check("async reset s_ready",    int'(s_ready),    31);
    check("async reset frame_tick", int'(frame_tick), 0);
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    wait_first_tick("re-release");
    for (int c = 0; c < NCH; c++) push(c, 0);
    measure();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
